// File: rtl/sr_bank_pkg.sv
// Shared types and next-state helper for the clocked set/reset register bank.
// A request pair is packed as {s, r}; the S=R=1 resolution is a compile-time mode.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_RST_DOM = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    typedef logic [1:0] sr_pair_t;

    localparam sr_pair_t SR_PAIR_NONE = 2'b00;
    localparam sr_pair_t SR_PAIR_RST  = 2'b01;
    localparam sr_pair_t SR_PAIR_SET  = 2'b10;
    localparam sr_pair_t SR_PAIR_BOTH = 2'b11;

    function automatic logic sr_next_q(input sr_pair_t pair, input logic q, input sr_mode_e mode);
        logic nq;
        nq = q;
        case (pair)
            SR_PAIR_SET: nq = 1'b1;
            SR_PAIR_RST: nq = 1'b0;
            SR_PAIR_BOTH: begin
                case (mode)
                    SR_SET_DOM: nq = 1'b1;
                    SR_RST_DOM: nq = 1'b0;
                    SR_TOGGLE:  nq = ~q;
                    default:    nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_chan.sv
// One channel of the register bank: input stability filter plus the stored bit.
// A pair acts only once it has been sampled identically on FILT+1 consecutive edges.
module sr_chan
    import sr_bank_pkg::*;
#(
    parameter int   FILT = 2,
    parameter int   MODE = 0,
    parameter logic INIT = 1'b0
)(
    input  logic clk,
    input  logic rst,
    input  logic s_i,
    input  logic r_i,
    output logic q_o,
    output logic qc_o,
    output logic conflict_d_o,
    output logic conflict_o
);

    localparam int                STAB_W    = (FILT > 0) ? $clog2(FILT + 1) : 1;
    localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(FILT);
    localparam sr_mode_e          MODE_E    = sr_mode_e'(MODE[1:0]);

    sr_pair_t          pair_now;
    sr_pair_t          pair_q;
    sr_pair_t          act;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic              qualified;
    logic              q_q;
    logic              q_d;
    logic              qc_q;
    logic              conflict_q;

    assign pair_now = {s_i, r_i};

    // stab counts how many earlier edges matched the current sample; with FILT=0
    // it is pinned at zero, so every sample qualifies.
    always_comb begin
        stab_d = '0;
        if (pair_now == pair_q) begin
            if (stab_q != STAB_FULL) begin
                stab_d = stab_q + STAB_W'(1);
            end else begin
                stab_d = stab_q;
            end
        end
        qualified    = (stab_d == STAB_FULL);
        act          = qualified ? pair_now : SR_PAIR_NONE;
        q_d          = sr_next_q(act, q_q, MODE_E);
        conflict_d_o = (act == SR_PAIR_BOTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q     <= SR_PAIR_NONE;
            stab_q     <= '0;
            q_q        <= INIT;
            qc_q       <= ~INIT;
            conflict_q <= 1'b0;
        end else begin
            pair_q     <= pair_now;
            stab_q     <= stab_d;
            q_q        <= q_d;
            qc_q       <= ~q_d;
            conflict_q <= conflict_d_o;
        end
    end

    assign q_o        = q_q;
    assign qc_o       = qc_q;
    assign conflict_o = conflict_q;

endmodule

// File: rtl/sr_reg_bank.sv
// Multi-channel clocked set/reset register bank with filtered inputs,
// per-channel conflict pulses, a sticky error flag and a saturating conflict counter.
module sr_reg_bank
    import sr_bank_pkg::*;
#(
    parameter int            CH    = 4,
    parameter int            FILT  = 2,
    parameter int            MODE  = 0,
    parameter int            CNT_W = 8,
    parameter logic [CH-1:0] INIT  = '0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    s,
    input  logic [CH-1:0]    r,
    input  logic             clr_err,
    output logic [CH-1:0]    q,
    output logic [CH-1:0]    qc,
    output logic [CH-1:0]    conflict,
    output logic             err_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $error("sr_reg_bank: MODE must be 0..3");
    end
    if (FILT < 0) begin : g_bad_filt
        $error("sr_reg_bank: FILT must be >= 0");
    end
    if (CH < 1 || CNT_W < 1) begin : g_bad_size
        $error("sr_reg_bank: CH and CNT_W must be >= 1");
    end

    logic [CH-1:0] conflict_d;
    logic          any_conflict;
    logic          err_q;
    logic          err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        sr_chan #(
            .FILT (FILT),
            .MODE (MODE),
            .INIT (INIT[gi])
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .s_i          (s[gi]),
            .r_i          (r[gi]),
            .q_o          (q[gi]),
            .qc_o         (qc[gi]),
            .conflict_d_o (conflict_d[gi]),
            .conflict_o   (conflict[gi])
        );
    end

    assign any_conflict = |conflict_d;

    // A conflict on the same edge as clr_err wins: the flag stays set and the
    // counter restarts at one rather than zero.
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if (clr_err) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
        if (any_conflict) begin
            err_d = 1'b1;
            if (clr_err) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_sticky   = err_q;
    assign conflict_cnt = cnt_q;

endmodule
